// File: rtl/key_pulse_conditioner.sv
// Per-key 2-flop sync and counter debounce; registered level plus one-cycle press/release strobes.
// Latency DEBOUNCE_CYCLES+1 edges after s1 samples a change; no backpressure, strobes are fire-and-forget.
module key_pulse_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic             s1;
    logic             s2;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Sync flops reset to 1 so a key held through reset is seen as a fresh press.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1        <= 1'b1;
        s2        <= 1'b1;
        state_q   <= UP;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1        <= key_n[i];
        s2        <= s1;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Count only while the synced level disagrees with the accepted state; any agreement restarts.
    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        UP: begin
          if (!s2) begin
            if (cnt_q == CNT_LAST) begin
              state_d = DOWN;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DOWN: begin
          if (s2) begin
            if (cnt_q == CNT_LAST) begin
              state_d   = UP;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = UP;
        end
      endcase
    end

    assign pressed[i]       = (state_q == DOWN);
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with DEBOUNCE_CYCLES=4, NUM_KEYS=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_key_pulse_conditioner;

  logic       clock;
  logic       reset_n;
  logic [3:0] key_n;
  logic [3:0] pressed;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  key_pulse_conditioner #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] key_n;
    logic [3:0] exp_pressed;
    logic [3:0] exp_press;
    logic [3:0] exp_release;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int edge_no, input logic [3:0] act,
                       input logic [3:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_no, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int edge_no, input logic [3:0] e_prs,
                           input logic [3:0] e_pp, input logic [3:0] e_rp);
    check({tag, ".pressed"}, edge_no, pressed, e_prs);
    check({tag, ".press_pulse"}, edge_no, press_pulse, e_pp);
    check({tag, ".release_pulse"}, edge_no, release_pulse, e_rp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0: held e1..e9, released e10+ ; ch1: 3-cycle bounce ; ch2: 0,1,0,0.. ; ch3 idle
    vecs[0]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b1010, 4'b0001, 4'b0001, 4'b0000};
    vecs[6]  = '{4'b1010, 4'b0001, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b1010, 4'b0101, 4'b0100, 4'b0000};
    vecs[8]  = '{4'b1010, 4'b0101, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b1011, 4'b0101, 4'b0000, 4'b0000};
    vecs[10] = '{4'b1011, 4'b0101, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1011, 4'b0101, 4'b0000, 4'b0000};
    vecs[12] = '{4'b1011, 4'b0101, 4'b0000, 4'b0000};
    vecs[13] = '{4'b1011, 4'b0101, 4'b0000, 4'b0000};
    vecs[14] = '{4'b1011, 4'b0100, 4'b0000, 4'b0001};
    vecs[15] = '{4'b1011, 4'b0100, 4'b0000, 4'b0000};
    vecs[16] = '{4'b1011, 4'b0100, 4'b0000, 4'b0000};

    // Keys held through reset: all four accepted together 6 edges after release.
    reset_n = 1'b0;
    key_n   = 4'b0000;
    #2;
    check_all("in_reset", 0, 4'b0000, 4'b0000, 4'b0000);
    step();
    step();
    check_all("in_reset_clocked", 0, 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check_all("held_thru_reset", e, (e >= 6) ? 4'b1111 : 4'b0000,
                (e == 6) ? 4'b1111 : 4'b0000, 4'b0000);
    end

    // Release all, then reset asynchronously with the release count at 2.
    key_n = 4'b1111;
    for (int e = 1; e <= 4; e++) step();
    check_all("pre_mid_reset", 4, 4'b1111, 4'b0000, 4'b0000);
    #3;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 0, 4'b0000, 4'b0000, 4'b0000);
    step();
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check_all("after_mid_reset", e, 4'b0000, 4'b0000, 4'b0000);
    end

    // Fresh reset with keys released, then the per-edge table.
    reset_n = 1'b0;
    key_n   = 4'b1111;
    step();
    reset_n = 1'b1;
    for (int v = 0; v < 17; v++) begin
      key_n = vecs[v].key_n;
      step();
      check_all("table", v + 1, vecs[v].exp_pressed, vecs[v].exp_press, vecs[v].exp_release);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
